background_scroll: RTL and testbench

Next-generation background tile renderer for the GPU. It adds per-line hardware scrolling with wrap-around, a parametrised pattern count and a parametrised nametable height. Each scanline is fetched during the previous line from synchronous nametable and pattern RAMs into a double-buffered line buffer; pixels are then streamed out as registered 2-bit RGB. It sits between the VRAM blocks (which own CPU access) and the GPU pixel mixer.

---
 rtl/background_scroll.sv | 170 +++++++++++++++++
 tb/tb_background_scroll.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/background_scroll.sv
// Background tile renderer: fetches one scrolled scanline into the back half of a
// double-buffered line buffer while the front half streams out registered 2-bit RGB.
module background_scroll #(
   parameter int unsigned PMBA_W  = 5,
   parameter int unsigned NT_ROWS = 30
) (
   input  logic              cpu_clk,
   input  logic              rst,
   input  logic              line_start_i,
   input  logic [7:0]        line_y_i,
   input  logic [7:0]        scroll_x_i,
   input  logic [7:0]        scroll_y_i,
   input  logic [5:0]        colors_i,
   output logic [9:0]        ntbl_addr_o,
   input  logic [PMBA_W+2:0] ntbl_data_i,
   output logic [PMBA_W+3:0] pmb_addr_o,
   input  logic [7:0]        pmb_data_i,
   input  logic [7:0]        pixel_x_i,
   output logic [1:0]        r_o,
   output logic [1:0]        g_o,
   output logic [1:0]        b_o,
   output logic              busy_o
);
   localparam int unsigned TILE_W   = PMBA_W + 3;
   localparam int unsigned PMB_AW   = PMBA_W + 4;
   localparam int unsigned WRAP_Y   = NT_ROWS * 8;
   localparam int unsigned LINE_LEN = 264;
   localparam logic [5:0]  LAST_T   = 6'd32;

   typedef enum logic [2:0] {S_IDLE, S_NT, S_PL, S_PR, S_ST} state_t;
   state_t state_q, state_d;

   logic [5:0]        t_q;
   logic [4:0]        row_q;
   logic [4:0]        coarse_q;
   logic [2:0]        inty_q;
   logic              front_q;
   logic [1:0]        valid_q;
   logic [2:0]        fine_q   [2];
   logic [5:0]        colors_q [2];
   logic [TILE_W-1:0] tile_q;
   logic [7:0]        left_q;
   logic [PMB_AW-1:0] pmb_addr_q;
   logic [2:0]        line_mem [2][LINE_LEN];

   // Vertical wrap of the requested line into the nametable
   logic [8:0] sum_y;
   logic [7:0] eff_y;
   always_comb begin
      sum_y = 9'(line_y_i) + 9'(scroll_y_i);
      eff_y = (sum_y >= 9'(WRAP_Y)) ? 8'(sum_y - 9'(WRAP_Y)) : 8'(sum_y);
   end

   // Pattern address: PL uses the tile arriving from the nametable this cycle
   logic [2:0] py_pl;
   always_comb begin
      py_pl      = ntbl_data_i[PMBA_W+1] ? (3'd7 - inty_q) : inty_q;
      pmb_addr_o = pmb_addr_q;
      if (state_q == S_PL) begin
         pmb_addr_o = {ntbl_data_i[PMBA_W-1:0], py_pl, 1'b0};
      end
   end

   // Eight line-buffer entries formed from the two pattern bytes
   logic [15:0] st_line;
   logic [2:0]  st_ent [8];
   logic        st_we;
   always_comb begin
      st_line = {left_q, pmb_data_i};
      st_we   = (state_q == S_ST) && !line_start_i;
      for (int k = 0; k < 8; k++) begin
         st_ent[k] = {tile_q[PMBA_W+2],
                      st_line[(tile_q[PMBA_W] ? 4'(2 * k) : 4'(14 - 2 * k)) +: 2]};
      end
   end

   // Front-bank read for the current display column
   logic [8:0] rd_idx;
   logic [2:0] rd_e;
   logic [2:0] rd_color;
   always_comb begin
      rd_idx   = 9'(pixel_x_i) + 9'(fine_q[front_q]);
      rd_e     = line_mem[front_q][rd_idx];
      rd_color = rd_e[2] ? colors_q[front_q][5:3] : colors_q[front_q][2:0];
   end

   always_comb begin
      state_d = state_q;
      if (line_start_i) begin
         state_d = S_NT;
      end else begin
         case (state_q)
            S_IDLE:  state_d = S_IDLE;
            S_NT:    state_d = S_PL;
            S_PL:    state_d = S_PR;
            S_PR:    state_d = S_ST;
            S_ST:    state_d = (t_q == LAST_T) ? S_IDLE : S_NT;
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge cpu_clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         t_q         <= '0;
         row_q       <= '0;
         coarse_q    <= '0;
         inty_q      <= '0;
         front_q     <= 1'b0;
         valid_q     <= '0;
         fine_q[0]   <= '0;
         fine_q[1]   <= '0;
         colors_q[0] <= '0;
         colors_q[1] <= '0;
         tile_q      <= '0;
         left_q      <= '0;
         pmb_addr_q  <= '0;
         ntbl_addr_o <= '0;
         busy_o      <= 1'b0;
         r_o         <= '0;
         g_o         <= '0;
         b_o         <= '0;
      end else begin
         state_q <= state_d;
         busy_o  <= (state_d != S_IDLE);
         if (line_start_i) begin
            // Swap: the old front becomes the new back and takes this line's settings
            front_q            <= ~front_q;
            valid_q[front_q]   <= 1'b0;
            fine_q[front_q]    <= scroll_x_i[2:0];
            colors_q[front_q]  <= colors_i;
            coarse_q           <= scroll_x_i[7:3];
            row_q              <= eff_y[7:3];
            inty_q             <= eff_y[2:0];
            t_q                <= '0;
            ntbl_addr_o        <= {eff_y[7:3], scroll_x_i[7:3]};
         end else begin
            case (state_q)
               S_PL: begin
                  tile_q     <= ntbl_data_i;
                  pmb_addr_q <= {ntbl_data_i[PMBA_W-1:0], py_pl, 1'b1};
               end
               S_PR: left_q <= pmb_data_i;
               S_ST: begin
                  t_q <= t_q + 6'd1;
                  if (t_q == LAST_T) begin
                     valid_q[~front_q] <= 1'b1;
                  end else begin
                     ntbl_addr_o <= {row_q, coarse_q + t_q[4:0] + 5'd1};
                  end
               end
               default: ;
            endcase
         end
         r_o <= valid_q[front_q] ? (rd_e[1:0] & {2{rd_color[2]}}) : 2'b00;
         g_o <= valid_q[front_q] ? (rd_e[1:0] & {2{rd_color[1]}}) : 2'b00;
         b_o <= valid_q[front_q] ? (rd_e[1:0] & {2{rd_color[0]}}) : 2'b00;
      end
   end

   // Line-buffer storage is not reset
   always_ff @(posedge cpu_clk) begin
      if (st_we) begin
         for (int k = 0; k < 8; k++) begin
            line_mem[~front_q][{t_q, 3'(k)}] <= st_ent[k];
         end
      end
   end
endmodule

// File: tb/tb_background_scroll.sv
// Scoreboarded bench for background_scroll with behavioural VRAM and a per-pixel
// reference model computed from world coordinates.
module tb_background_scroll;
   localparam int unsigned PMBA_W  = 5;
   localparam int unsigned NT_ROWS = 30;
   localparam int          LINE_H  = NT_ROWS * 8;

   logic              cpu_clk = 1'b0;
   logic              rst = 1'b1;
   logic              line_start_i = 1'b0;
   logic [7:0]        line_y_i = '0;
   logic [7:0]        scroll_x_i = '0;
   logic [7:0]        scroll_y_i = '0;
   logic [5:0]        colors_i = '0;
   logic [9:0]        ntbl_addr_o;
   logic [PMBA_W+2:0] ntbl_data_i;
   logic [PMBA_W+3:0] pmb_addr_o;
   logic [7:0]        pmb_data_i;
   logic [7:0]        pixel_x_i = '0;
   logic [1:0]        r_o, g_o, b_o;
   logic              busy_o;

   background_scroll #(.PMBA_W(PMBA_W), .NT_ROWS(NT_ROWS)) dut (
      .cpu_clk(cpu_clk), .rst(rst), .line_start_i(line_start_i), .line_y_i(line_y_i),
      .scroll_x_i(scroll_x_i), .scroll_y_i(scroll_y_i), .colors_i(colors_i),
      .ntbl_addr_o(ntbl_addr_o), .ntbl_data_i(ntbl_data_i), .pmb_addr_o(pmb_addr_o),
      .pmb_data_i(pmb_data_i), .pixel_x_i(pixel_x_i), .r_o(r_o), .g_o(g_o), .b_o(b_o),
      .busy_o(busy_o)
   );

   always #5 cpu_clk = ~cpu_clk;

   // Synchronous VRAM models, one cycle of read latency
   logic [7:0] ntbl_mem [1024];
   logic [7:0] pmb_mem  [512];
   always @(posedge cpu_clk) begin
      ntbl_data_i <= ntbl_mem[ntbl_addr_o];
      pmb_data_i  <= pmb_mem[pmb_addr_o];
   end

   int cyc = 0;
   always @(posedge cpu_clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   // Reference model state: expected RGB per display column for each bank
   logic [5:0] exp_front [256];
   logic [5:0] exp_back  [256];
   bit         front_valid = 1'b0;
   bit         back_started = 1'b0;
   int         last_start_edge = 0;

   logic [5:0] exp_q [$];
   logic       pix_req = 1'b0;
   logic       req_d = 1'b0;

   always @(posedge cpu_clk) req_d <= pix_req;

   // Monitor: one registered pixel is presented the cycle after each request
   always @(negedge cpu_clk) begin
      if (req_d) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL pixel: output with empty scoreboard, actual=%h", {r_o, g_o, b_o});
         end else begin
            logic [5:0] e;
            e = exp_q.pop_front();
            if ({r_o, g_o, b_o} !== e) begin
               errors++;
               $display("FAIL pixel at t=%0t: actual rgb=%h required rgb=%h", $time, {r_o, g_o, b_o}, e);
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: actual=%0d required=%0d", name, act, req);
      end
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 1024; i++) ntbl_mem[i] = 8'h00;
      for (int i = 0; i < 512; i++) pmb_mem[i] = 8'h00;
   endtask

   task automatic rand_mem();
      for (int i = 0; i < 1024; i++) ntbl_mem[i] = 8'($urandom);
      for (int i = 0; i < 512; i++) pmb_mem[i] = 8'($urandom);
   endtask

   // Expected colour of every display column, straight from world coordinates
   task automatic compute_back(input int ly, input int sx, input int sy, input logic [5:0] col);
      int ey, row, y, wx, c, fx, py, p, base;
      logic [7:0]  tile;
      logic [15:0] ln;
      logic [2:0]  color;
      logic [1:0]  l2;
      ey  = (ly + sy) % LINE_H;
      row = ey / 8;
      y   = ey % 8;
      for (int x = 0; x < 256; x++) begin
         wx    = (sx + x) % 256;
         c     = wx / 8;
         fx    = wx % 8;
         tile  = ntbl_mem[row * 32 + c];
         py    = tile[PMBA_W+1] ? 7 - y : y;
         base  = int'(tile[PMBA_W-1:0]) * 16 + py * 2;
         ln    = {pmb_mem[base], pmb_mem[base + 1]};
         p     = tile[PMBA_W] ? 7 - fx : fx;
         l2    = 2'((ln >> (14 - 2 * p)) & 16'h3);
         color = tile[PMBA_W+2] ? col[5:3] : col[2:0];
         exp_back[x] = {l2 & {2{color[2]}}, l2 & {2{color[1]}}, l2 & {2{color[0]}}};
      end
   endtask

   // Called just after a rising edge; returns in the first fetch cycle (NT of tile 0)
   task automatic start_line(input int ly, input int sx, input int sy, input logic [5:0] col);
      int e;
      e = cyc + 1;
      front_valid = back_started && (e - last_start_edge >= 133);
      exp_front = exp_back;
      compute_back(ly, sx, sy, col);
      back_started = 1'b1;
      last_start_edge = e;
      line_y_i = 8'(ly);
      scroll_x_i = 8'(sx);
      scroll_y_i = 8'(sy);
      colors_i = col;
      line_start_i = 1'b1;
      @(posedge cpu_clk);
      #1 line_start_i = 1'b0;
   endtask

   task automatic drive_pixel(input int x, input logic [5:0] e);
      pixel_x_i = 8'(x);
      pix_req = 1'b1;
      exp_q.push_back(e);
      @(posedge cpu_clk);
      #1 pix_req = 1'b0;
   endtask

   task automatic model_pixel(input int x);
      drive_pixel(x, front_valid ? exp_front[x] : 6'h00);
   endtask

   task automatic busy_len(output int n);
      n = 0;
      while (busy_o === 1'b1 && n < 400) begin
         n++;
         @(posedge cpu_clk);
         #1;
      end
      if (n >= 400) begin
         checks++;
         errors++;
         $display("FAIL busy_timeout: actual=busy after %0d cycles required=idle", n);
      end
   endtask

   task automatic wait_idle();
      int n;
      busy_len(n);
   endtask

   task automatic model_reset();
      front_valid = 1'b0;
      back_started = 1'b0;
   endtask

   int unsc_r [8] = '{3, 2, 1, 0, 0, 1, 2, 3};
   int asym_r [8] = '{0, 0, 0, 0, 0, 1, 2, 3};

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int sx, sy, ly;
      clear_mem();
      compute_back(0, 0, 0, 6'h00);
      repeat (2) @(posedge cpu_clk);
      #1;
      check("reset_busy", 32'(busy_o), 0);
      check("reset_ntbl_addr", 32'(ntbl_addr_o), 0);
      check("reset_pmb_addr", 32'(pmb_addr_o), 0);
      check("reset_rgb", 32'({r_o, g_o, b_o}), 0);
      rst = 1'b0;
      @(posedge cpu_clk);
      #1;

      // Unscrolled line, then mid-fetch reset
      ntbl_mem[0] = 8'h01;
      pmb_mem[16] = 8'hE4;
      pmb_mem[17] = 8'h1B;
      start_line(0, 0, 0, 6'b001_100);
      check("nt_addr_unscrolled", 32'(ntbl_addr_o), 0);
      check("busy_first_cycle", 32'(busy_o), 1);
      @(posedge cpu_clk);
      #1;
      check("pl_addr_unscrolled", 32'(pmb_addr_o), 16);
      wait_idle();
      start_line(1, 0, 0, 6'b001_100);
      for (int i = 0; i < 8; i++) drive_pixel(i, {2'(unsc_r[i]), 4'b0000});
      pixel_x_i = 8'd0;
      repeat (33) @(posedge cpu_clk);
      #1;
      check("rgb_before_reset", 32'({r_o, g_o, b_o}), 32'h30);
      rst = 1'b1;
      #1;
      check("busy_async_reset", 32'(busy_o), 0);
      check("rgb_async_reset", 32'({r_o, g_o, b_o}), 0);
      @(posedge cpu_clk);
      #1 rst = 1'b0;
      model_reset();
      start_line(0, 0, 0, 6'b001_100);
      busy_len(n);
      check("busy_len_after_reset", 32'(n), 132);
      check("busy_low_after_fetch", 32'(busy_o), 0);

      // Flipped tile with an asymmetric pattern
      clear_mem();
      ntbl_mem[0] = 8'h61;
      pmb_mem[16] = 8'hE4;
      pmb_mem[17] = 8'h00;
      start_line(7, 0, 0, 6'b001_100);
      check("nt_addr_flip", 32'(ntbl_addr_o), 0);
      @(posedge cpu_clk);
      #1;
      check("pl_addr_vflip", 32'(pmb_addr_o), 16);
      @(posedge cpu_clk);
      #1;
      check("pr_addr_vflip", 32'(pmb_addr_o), 17);
      wait_idle();
      start_line(0, 0, 0, 6'b001_100);
      for (int i = 0; i < 8; i++) drive_pixel(i, {2'(asym_r[i]), 4'b0000});
      wait_idle();

      // Vertical wrap and horizontal column wrap addressing
      clear_mem();
      ntbl_mem[0] = 8'h02;
      start_line(10, 0, 236, 6'b111_111);
      check("nt_addr_vwrap", 32'(ntbl_addr_o), 0);
      @(posedge cpu_clk);
      #1;
      check("pl_addr_vwrap", 32'(pmb_addr_o), 44);
      wait_idle();
      start_line(0, 255, 0, 6'b111_111);
      check("nt_addr_hwrap_t0", 32'(ntbl_addr_o), 31);
      repeat (4) @(posedge cpu_clk);
      #1;
      check("nt_addr_hwrap_t1", 32'(ntbl_addr_o), 0);
      wait_idle();

      // Restart at cycle 50 of a fetch
      rand_mem();
      start_line(int'($urandom_range(0, LINE_H - 1)), int'($urandom_range(0, 255)),
                 int'($urandom_range(0, LINE_H - 1)), 6'($urandom));
      repeat (49) @(posedge cpu_clk);
      #1;
      start_line(int'($urandom_range(0, LINE_H - 1)), int'($urandom_range(0, 255)),
                 int'($urandom_range(0, LINE_H - 1)), 6'($urandom));
      busy_len(n);
      check("busy_len_restart", 32'(n), 132);
      for (int i = 0; i < 6; i++) model_pixel(int'($urandom_range(0, 255)));
      start_line(0, 0, 0, 6'($urandom));
      for (int i = 0; i < 12; i++) model_pixel(int'($urandom_range(0, 255)));

      // Randomised lines; each start shows the previous fetch
      for (int it = 0; it < 10; it++) begin
         wait_idle();
         rand_mem();
         sx = int'($urandom_range(0, 255));
         sy = int'($urandom_range(0, LINE_H - 1));
         ly = int'($urandom_range(0, LINE_H - 1));
         if (it == 0) sx = 13;
         if (it == 1) sx = 255;
         if (it == 2) begin
            sy = 236;
            ly = 10;
         end
         start_line(ly, sx, sy, 6'($urandom));
         model_pixel(0);
         model_pixel(3);
         model_pixel(250);
         model_pixel(255);
         for (int i = 0; i < 20; i++) model_pixel(int'($urandom_range(0, 255)));
      end
      wait_idle();
      start_line(0, 0, 0, 6'($urandom));
      for (int i = 0; i < 16; i++) model_pixel(int'($urandom_range(0, 255)));
      wait_idle();

      repeat (3) @(posedge cpu_clk);
      check("scoreboard_drained", 32'(exp_q.size()), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
